// File: rtl/tl_slave_beh.sv
// rtl/tl_slave_beh.sv - behavioral TileLink-UH responder with local backing memory
module tl_slave_beh #(
  parameter int                  SRC_SIZE   = 2,
  parameter int                  SINK_SIZE  = 3,
  parameter int                  BUS_SIZE   = 8,
  parameter int                  ADR_WIDTH  = 32,
  parameter logic [ADR_WIDTH-1:0] BASE_ADDR = 32'h7000_0000,
  parameter int                  DEPTH_LOG2 = 8,
  parameter int                  MAX_SIZE   = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tl_slave_a_valid,
  output logic                    tl_slave_a_ready,
  input  logic [2:0]              tl_slave_a_bits_opcode,
  input  logic [2:0]              tl_slave_a_bits_param,
  input  logic [3:0]              tl_slave_a_bits_size,
  input  logic [SRC_SIZE-1:0]     tl_slave_a_bits_source,
  input  logic [ADR_WIDTH-1:0]    tl_slave_a_bits_address,
  input  logic [BUS_SIZE-1:0]     tl_slave_a_bits_mask,
  input  logic [8*BUS_SIZE-1:0]   tl_slave_a_bits_data,
  input  logic                    tl_slave_a_bits_corrupt,
  output logic                    tl_slave_d_valid,
  input  logic                    tl_slave_d_ready,
  output logic [2:0]              tl_slave_d_bits_opcode,
  output logic [1:0]              tl_slave_d_bits_param,
  output logic [3:0]              tl_slave_d_bits_size,
  output logic [SRC_SIZE-1:0]     tl_slave_d_bits_source,
  output logic [SINK_SIZE-1:0]    tl_slave_d_bits_sink,
  output logic                    tl_slave_d_bits_denied,
  output logic [8*BUS_SIZE-1:0]   tl_slave_d_bits_data,
  output logic                    tl_slave_d_bits_corrupt
);

  localparam int LG_BUS = $clog2(BUS_SIZE);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int EW     = ADR_WIDTH + 2;
  localparam logic [EW-1:0] LIMIT = EW'(BASE_ADDR) + (EW'(1) << (DEPTH_LOG2 + LG_BUS));
  localparam logic [3:0] LG4    = 4'(LG_BUS);
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {IDLE, WR, WACK, RD} state_t;

  state_t                  state;
  logic [11:0]             beat;
  logic [11:0]             last_q;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [3:0]              size_q;
  logic [SRC_SIZE-1:0]     source_q;
  logic                    denied_q;
  logic                    bad_q;

  logic [8*BUS_SIZE-1:0]   mem [0:DEPTH-1];

  logic                    a_hs;
  logic                    d_hs;
  logic                    op_put;
  logic                    op_get;
  logic                    op_bad;
  logic [ADR_WIDTH-1:0]    offset;
  logic [EW-1:0]           end_addr;
  logic                    deny;
  logic [11:0]             last_now;
  logic [DEPTH_LOG2-1:0]   word_base;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    wr_go;
  logic                    unused_bits;

  assign a_hs      = tl_slave_a_valid & tl_slave_a_ready;
  assign d_hs      = tl_slave_d_valid & tl_slave_d_ready;
  assign op_put    = (tl_slave_a_bits_opcode == 3'd0) || (tl_slave_a_bits_opcode == 3'd1);
  assign op_get    = (tl_slave_a_bits_opcode == 3'd4);
  assign op_bad    = !(op_put || op_get);
  assign offset    = tl_slave_a_bits_address - BASE_ADDR;
  assign end_addr  = {2'b00, tl_slave_a_bits_address} + (EW'(1) << tl_slave_a_bits_size);
  assign deny      = (tl_slave_a_bits_size > MAX_SZ) || (tl_slave_a_bits_address < BASE_ADDR) ||
                     (end_addr > LIMIT) || op_bad;
  assign last_now  = (tl_slave_a_bits_size <= LG4) ? 12'd0
                   : ((12'd1 << (tl_slave_a_bits_size - LG4)) - 12'd1);
  assign word_base = offset[LG_BUS +: DEPTH_LOG2];
  assign unused_bits = ^{tl_slave_a_bits_param, offset};

  // Beat 0 of a Put is written straight from IDLE; later beats use the running index
  assign wr_idx = (state == IDLE) ? word_base : idx;
  assign wr_go  = reset && a_hs && !tl_slave_a_bits_corrupt &&
                  (((state == IDLE) && op_put && !deny) || ((state == WR) && !denied_q));

  assign tl_slave_d_bits_param = 2'd0;
  assign tl_slave_d_bits_sink  = '0;
  assign tl_slave_d_bits_data  = ((state == RD) && !denied_q) ? mem[idx] : '0;

  // Backing store: byte-lane writes, deliberately not cleared by reset
  always_ff @(posedge clock) begin
    if (wr_go) begin
      for (int i = 0; i < BUS_SIZE; i++) begin
        if (tl_slave_a_bits_mask[i]) mem[wr_idx][8*i +: 8] <= tl_slave_a_bits_data[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered channel outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                   <= IDLE;
      tl_slave_a_ready        <= 1'b0;
      tl_slave_d_valid        <= 1'b0;
      tl_slave_d_bits_opcode  <= 3'd0;
      tl_slave_d_bits_size    <= 4'd0;
      tl_slave_d_bits_source  <= '0;
      tl_slave_d_bits_denied  <= 1'b0;
      tl_slave_d_bits_corrupt <= 1'b0;
      beat                    <= 12'd0;
      last_q                  <= 12'd0;
      idx                     <= '0;
      size_q                  <= 4'd0;
      source_q                <= '0;
      denied_q                <= 1'b0;
      bad_q                   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tl_slave_a_ready <= 1'b1;
          if (a_hs) begin
            size_q   <= tl_slave_a_bits_size;
            source_q <= tl_slave_a_bits_source;
            denied_q <= deny;
            bad_q    <= op_bad;
            last_q   <= last_now;
            if (op_get || (op_bad && last_now == 12'd0)) begin
              state                   <= RD;
              tl_slave_a_ready        <= 1'b0;
              tl_slave_d_valid        <= 1'b1;
              tl_slave_d_bits_opcode  <= 3'd1;
              tl_slave_d_bits_size    <= tl_slave_a_bits_size;
              tl_slave_d_bits_source  <= tl_slave_a_bits_source;
              tl_slave_d_bits_denied  <= deny;
              tl_slave_d_bits_corrupt <= deny;
              beat                    <= 12'd0;
              idx                     <= word_base;
            end else if (last_now == 12'd0) begin
              state                   <= WACK;
              tl_slave_a_ready        <= 1'b0;
              tl_slave_d_valid        <= 1'b1;
              tl_slave_d_bits_opcode  <= 3'd0;
              tl_slave_d_bits_size    <= tl_slave_a_bits_size;
              tl_slave_d_bits_source  <= tl_slave_a_bits_source;
              tl_slave_d_bits_denied  <= deny;
              tl_slave_d_bits_corrupt <= 1'b0;
            end else begin
              state <= WR;
              beat  <= 12'd1;
              idx   <= word_base + IDX_ONE;
            end
          end
        end
        WR: begin
          if (a_hs) begin
            if (beat == last_q) begin
              state                   <= bad_q ? RD : WACK;
              tl_slave_a_ready        <= 1'b0;
              tl_slave_d_valid        <= 1'b1;
              tl_slave_d_bits_opcode  <= bad_q ? 3'd1 : 3'd0;
              tl_slave_d_bits_size    <= size_q;
              tl_slave_d_bits_source  <= source_q;
              tl_slave_d_bits_denied  <= denied_q;
              tl_slave_d_bits_corrupt <= bad_q;
              beat                    <= 12'd0;
            end else begin
              beat <= beat + 12'd1;
              idx  <= idx + IDX_ONE;
            end
          end
        end
        WACK, RD: begin
          if (d_hs) begin
            if (state == WACK || beat == last_q) begin
              state                   <= IDLE;
              tl_slave_a_ready        <= 1'b1;
              tl_slave_d_valid        <= 1'b0;
              tl_slave_d_bits_opcode  <= 3'd0;
              tl_slave_d_bits_size    <= 4'd0;
              tl_slave_d_bits_source  <= '0;
              tl_slave_d_bits_denied  <= 1'b0;
              tl_slave_d_bits_corrupt <= 1'b0;
              beat                    <= 12'd0;
            end else begin
              beat <= beat + 12'd1;
              idx  <= idx + IDX_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_slave_beh.sv
// tb/tb_tl_slave_beh.sv - scoreboard testbench for tl_slave_beh
module tb_tl_slave_beh;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [3:0]  a_size = 4'd0;
  logic [1:0]  a_source = 2'd0;
  logic [31:0] a_address = 32'd0;
  logic [7:0]  a_mask = 8'd0;
  logic [63:0] a_data = 64'd0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [1:0]  d_source;
  logic [2:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [1:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } exp_t;

  exp_t exq[$];
  int total = 0;
  int bad = 0;

  tl_slave_beh dut (
    .clock(clock), .reset(reset),
    .tl_slave_a_valid(a_valid), .tl_slave_a_ready(a_ready),
    .tl_slave_a_bits_opcode(a_opcode), .tl_slave_a_bits_param(a_param),
    .tl_slave_a_bits_size(a_size), .tl_slave_a_bits_source(a_source),
    .tl_slave_a_bits_address(a_address), .tl_slave_a_bits_mask(a_mask),
    .tl_slave_a_bits_data(a_data), .tl_slave_a_bits_corrupt(a_corrupt),
    .tl_slave_d_valid(d_valid), .tl_slave_d_ready(d_ready),
    .tl_slave_d_bits_opcode(d_opcode), .tl_slave_d_bits_param(d_param),
    .tl_slave_d_bits_size(d_size), .tl_slave_d_bits_source(d_source),
    .tl_slave_d_bits_sink(d_sink), .tl_slave_d_bits_denied(d_denied),
    .tl_slave_d_bits_data(d_data), .tl_slave_d_bits_corrupt(d_corrupt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each D handshake, checks idle bits otherwise
  always @(negedge clock) begin
    if (reset && d_valid && d_ready) begin
      if (exq.size() == 0) begin
        chk("unexpected_d_beat", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exq.pop_front();
        chk("d_opcode", 64'(d_opcode), 64'(e.op));
        chk("d_size", 64'(d_size), 64'(e.size));
        chk("d_source", 64'(d_source), 64'(e.src));
        chk("d_denied", 64'(d_denied), 64'(e.denied));
        chk("d_corrupt", 64'(d_corrupt), 64'(e.corrupt));
        chk("d_data", d_data, e.data);
        chk("d_param_sink", 64'({d_param, d_sink}), 64'd0);
      end
    end else if (reset && !d_valid) begin
      chk("idle_d_bits", 64'({d_opcode, d_size, d_source, d_denied, d_corrupt}) | d_data, 64'd0);
    end
  end

  // Present one A beat and return just after the handshake edge
  task automatic a_beat(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [31:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic corrupt);
    int n;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
    n = 0;
    @(negedge clock);
    while (!a_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!a_ready) chk("a_ready_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                          input logic den, input logic cor, input logic [63:0] data);
    exp_t e;
    e.op = op; e.size = sz; e.src = src; e.denied = den; e.corrupt = cor; e.data = data;
    exq.push_back(e);
  endtask

  function automatic int beats_of(input logic [3:0] sz);
    return (sz <= 4'd3) ? 1 : (1 << (sz - 4'd3));
  endfunction

  task automatic put(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                     input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] base,
                     input logic corrupt, input logic den);
    if (op == 3'd0 || op == 3'd1) push_exp(3'd0, sz, src, den, 1'b0, 64'd0);
    else push_exp(3'd1, sz, src, 1'b1, 1'b1, 64'd0);
    for (int i = 0; i < beats_of(sz); i++) a_beat(op, sz, src, addr, mask, base + 64'(i), corrupt);
    a_valid = 1'b0;
    @(negedge clock);
    chk("ack_latency", 64'(d_valid), 64'd1);
  endtask

  task automatic get(input logic [3:0] sz, input logic [1:0] src, input logic [31:0] addr,
                     input logic [63:0] base, input logic den);
    for (int i = 0; i < beats_of(sz); i++) push_exp(3'd1, sz, src, den, den, den ? 64'd0 : base + 64'(i));
    a_beat(3'd4, sz, src, addr, 8'hFF, 64'd0, 1'b0);
    a_valid = 1'b0;
    @(negedge clock);
    chk("read_latency", 64'(d_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clock);
      #2;
      if (exq.size() == 0 && !d_valid) break;
      n++;
    end
    if (exq.size() != 0 || d_valid) chk("drain_timeout", 64'(exq.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_a_ready", 64'(a_ready), 64'd0);
    chk("reset_d_valid", 64'(d_valid), 64'd0);
    chk("reset_d_data", d_data, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("post_reset_a_ready", 64'(a_ready), 64'd1);
    @(posedge clock); #1;

    put(3'd0, 4'd3, 2'd1, 32'h7000_0010, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0); drain();
    get(4'd3, 2'd1, 32'h7000_0010, 64'h1122334455667788, 1'b0); drain();
    put(3'd0, 4'd6, 2'd2, 32'h7000_0040, 8'hFF, 64'd0, 1'b0, 1'b0); drain();
    get(4'd6, 2'd3, 32'h7000_0040, 64'd0, 1'b0); drain();
    put(3'd1, 4'd3, 2'd0, 32'h7000_0010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, 1'b0); drain();
    get(4'd3, 2'd0, 32'h7000_0010, 64'h11223344BBBBBBBB, 1'b0); drain();
    get(4'd3, 2'd2, 32'h6FFF_FFF8, 64'd0, 1'b1); drain();
    put(3'd0, 4'd7, 2'd1, 32'h7000_0040, 8'hFF, 64'hDEAD0000, 1'b0, 1'b1); drain();

    // Backpressure on the 8-beat read of the untouched burst region
    d_ready = 1'b0;
    get(4'd6, 2'd2, 32'h7000_0040, 64'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_d_valid", 64'(d_valid), 64'd1);
      chk("stall_d_data", d_data, 64'd0);
      chk("stall_d_source", 64'(d_source), 64'd2);
    end
    @(posedge clock); #1;
    d_ready = 1'b1;
    drain();

    put(3'd2, 4'd3, 2'd2, 32'h7000_0020, 8'hFF, 64'h1234, 1'b0, 1'b1); drain();
    put(3'd0, 4'd3, 2'd3, 32'h7000_07F8, 8'hFF, 64'h55AA55AA, 1'b0, 1'b0); drain();
    get(4'd3, 2'd3, 32'h7000_07F8, 64'h55AA55AA, 1'b0); drain();
    get(4'd3, 2'd1, 32'h7000_0800, 64'd0, 1'b1); drain();
    put(3'd0, 4'd3, 2'd0, 32'h7000_0018, 8'hFF, 64'hCAFEF00D, 1'b0, 1'b0); drain();
    put(3'd0, 4'd3, 2'd0, 32'h7000_0018, 8'hFF, 64'hBADBAD, 1'b1, 1'b0); drain();
    get(4'd3, 2'd0, 32'h7000_0018, 64'hCAFEF00D, 1'b0); drain();

    // Reset while beat 3 of an 8-beat Put is on the bus
    for (int i = 0; i < 3; i++) a_beat(3'd0, 4'd6, 2'd1, 32'h7000_0080, 8'hFF, 64'h100 + 64'(i), 1'b0);
    a_data = 64'h103;
    reset = 1'b0;
    @(posedge clock); #1;
    a_valid = 1'b0;
    @(negedge clock);
    chk("midreset_a_ready", 64'(a_ready), 64'd0);
    chk("midreset_d_valid", 64'(d_valid), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("release_a_ready", 64'(a_ready), 64'd1);
    @(posedge clock); #1;
    get(4'd4, 2'd1, 32'h7000_0080, 64'h100, 1'b0); drain();
    get(4'd3, 2'd1, 32'h7000_0090, 64'h102, 1'b0); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_slave_beh.md
# tl_slave_beh

Behavioral TileLink-UH responder with a local backing memory, the slave-side counterpart of `tl_master_beh` for co-simulation. It is bound to any memory-mapped TileLink client port in the cosim testbench (for example, `RocketTile_beh` traffic routed through the crossbar) so that master-driven transactions complete without the real peripheral. It accepts Get, PutFullData and PutPartialData bursts on channel A and returns AccessAckData or AccessAck on channel D. It handles one outstanding transaction at a time.

## Interface
Parameters:
- SRC_SIZE, 2, width of source ID
- SINK_SIZE, 3, width of sink ID
- BUS_SIZE, 8, data bus width in bytes (power of 2)
- ADR_WIDTH, 32, address width
- BASE_ADDR, 32'h7000_0000, first byte address served
- DEPTH_LOG2, 8, log2 of memory depth in BUS_SIZE-byte words
- MAX_SIZE, 6, largest legal log2 transfer size

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; all state updates on clock while reset==0
- tl_slave_a_valid  in  1  A-channel valid
- tl_slave_a_ready  out  1  A-channel ready
- tl_slave_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get; others unsupported
- tl_slave_a_bits_param  in  3  ignored
- tl_slave_a_bits_size  in  4  log2 bytes
- tl_slave_a_bits_source  in  SRC_SIZE  requester ID
- tl_slave_a_bits_address  in  ADR_WIDTH  byte address, size-aligned
- tl_slave_a_bits_mask  in  BUS_SIZE  byte-lane enables
- tl_slave_a_bits_data  in  8*BUS_SIZE  write data
- tl_slave_a_bits_corrupt  in  1  beat corrupt flag
- tl_slave_d_valid  out  1  D-channel valid
- tl_slave_d_ready  in  1  D-channel ready
- tl_slave_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- tl_slave_d_bits_param  out  2  always 0
- tl_slave_d_bits_size  out  4  echo of request size
- tl_slave_d_bits_source  out  SRC_SIZE  echo of request source
- tl_slave_d_bits_sink  out  SINK_SIZE  always 0
- tl_slave_d_bits_denied  out  1  request refused
- tl_slave_d_bits_data  out  8*BUS_SIZE  read data
- tl_slave_d_bits_corrupt  out  1  data invalid

## Operation
- Beats: N = (size <= log2(BUS_SIZE)) ? 1 : 2^size / BUS_SIZE. The beat counter is 12 bits.
- Word index: idx = ((address - BASE_ADDR) >> log2(BUS_SIZE)) + beat.
- Denied if any of the following is true:
  - size > MAX_SIZE;
  - address < BASE_ADDR;
  - address + 2^size > BASE_ADDR + 2^DEPTH_LOG2*BUS_SIZE;
  - opcode is unsupported.
- Size, source, opcode and denied are latched on the first A handshake.
- FSM states are IDLE, WR, WACK and RD.
  - IDLE: a_ready=1. On a Put handshake, write beat 0, then go to WACK if N==1, else to WR. On a Get handshake, go to RD. Unsupported opcodes are treated as Put for beat consumption and as Get for the response: AccessAckData with denied=1.
  - WR: a_ready=1. Write each handshaken beat. After beat N-1 is handshaken, go to WACK.
  - WACK: a_ready=0, d_valid=1, opcode=0. On d handshake, go to IDLE.
  - RD: a_ready=0, d_valid=1, opcode=1. data = mem[idx] via asynchronous read of the registered index. Each d handshake advances the beat. After beat N-1, go to IDLE.
- Writes: byte lane i is updated only if mask[i]=1, denied=0, and beat corrupt=0. A corrupt Put beat is dropped, and the final ack has denied=0.
- Denied Get: data=0 and corrupt=1 on every beat. Denied Put: no memory change, ack with denied=1.
- The memory is not cleared by reset.

## Timing
- Reset (reset==0): a_ready=0, d_valid=0, all d_bits=0, FSM=IDLE, beat counter=0. An in-flight burst is abandoned. Already-written beats remain in memory.
- First cycle after reset deasserts: a_ready=1.
- Write ack: d_valid rises the cycle after the last A beat handshake.
- Read response: first beat d_valid rises the cycle after the A handshake, which is 1-cycle latency. Subsequent beats follow one per cycle while d_ready=1.
- Handshake rules:
  - d_valid and all d_bits are held stable while d_valid=1 and d_ready=0.
  - d_valid never depends combinationally on d_ready.
  - a_ready depends only on state.
- Outside WACK/RD, all d_bits are 0.
- Back-to-back: the cycle after the final D handshake the FSM is in IDLE with a_ready=1. No A acceptance in the same cycle as the final D beat.

## Test plan
- Put then Get: PutFull size=3 to 0x7000_0010, data 0x1122334455667788, mask 0xFF → AccessAck, denied=0. Get size=3 at the same address → AccessAckData with data 0x1122334455667788 one cycle after the A handshake.
- Burst: PutFull size=6 (8 beats, data = beat index) to 0x7000_0040 → a single AccessAck after beat 7. Get size=6 → 8 beats with data 0..7, source echoed.
- Partial: PutPartial mask 0x0F, data 0xAAAAAAAA_BBBBBBBB over the address from the first test → a subsequent read returns 0x11223344_BBBBBBBB.
- Errors:
  - Get at 0x6FFF_FFF8 → denied=1, corrupt=1, data=0.
  - Put size=7 → all 16 beats accepted, ack denied=1, memory unchanged.
  - Opcode 2 → AccessAckData denied=1.
- Backpressure: d_ready held 0 for 5 cycles during an 8-beat Get → d_bits stable, no beat skipped or duplicated.
- Reset mid-burst: assert reset during beat 3 of an 8-beat Put → next cycle a_ready=0, d_valid=0. After release, a_ready=1 and a Get of beats 0–2 returns the written data.
